// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: oversamples external bclk/lrclk, serializes per-channel holding registers MSB-first.
// Build option I2S_TX_UNDERRUN_MUTE_EN: send zeros on underrun instead of repeating the last sample.
module i2s_tx_serializer #(
  parameter int DATA_W      = 16,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bclk_in,
  input  logic              lrclk_in,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              sample_ch,
  output logic              sdata_out,
  output logic              load_strobe,
  output logic              load_ch,
  output logic              underrun,
  output logic              frame_err
);

  typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

  localparam logic [5:0] SLOT_LEN = 6'(SLOT_W);
  localparam logic [5:0] CNT_MAX  = 6'd63;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic                   bclk_d;
  logic                   fe_raw;
  logic                   fe_q;
  logic                   lr_q;
  logic                   lr_prev;
  logic                   lr_chg;

  state_t state;
  state_t state_nx;
  logic   do_load;
  logic   do_shift;
  logic   chk_frame;

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic              fresh_l;
  logic              fresh_r;
  logic [5:0]        slot_cnt;

  logic              bypass;
  logic              sel_fresh;
  logic              load_underrun;
  logic [DATA_W-1:0] sel_hold;
  logic [DATA_W-1:0] fallback;
  logic [DATA_W-1:0] load_word;

  // fe is registered once more so lr_q and fe_q describe the same bclk edge (SYNC_STAGES >= 2).
  assign fe_raw = bclk_d & ~bclk_sync[SYNC_STAGES-1];
  assign lr_chg = fe_q && (lr_q != lr_prev);

  always_ff @(posedge clk) begin
    if (!reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      bclk_d    <= 1'b0;
      fe_q      <= 1'b0;
      lr_q      <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_in};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      fe_q      <= fe_raw;
      lr_q      <= lr_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT_SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    chk_frame = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (lr_chg) begin
          do_load  = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        do_shift  = fe_q;
        do_load   = lr_chg;
        chk_frame = lr_chg && (slot_cnt != SLOT_LEN);
      end
      default: state_nx = WAIT_SYNC;
    endcase
  end

  // A write aimed at the channel being loaded this very cycle goes straight into the shifter.
  always_comb begin
    bypass    = sample_valid && (sample_ch == lr_q);
    sel_fresh = lr_q ? fresh_r : fresh_l;
    sel_hold  = lr_q ? hold_r : hold_l;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    fallback  = '0;
`else
    fallback  = sel_hold;
`endif
    load_word     = fallback;
    load_underrun = 1'b0;
    if (bypass)         load_word = sample_in;
    else if (sel_fresh) load_word = sel_hold;
    else                load_underrun = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sdata_out   <= 1'b0;
      load_strobe <= 1'b0;
      load_ch     <= 1'b0;
      underrun    <= 1'b0;
      frame_err   <= 1'b0;
      shreg       <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      fresh_l     <= 1'b0;
      fresh_r     <= 1'b0;
      slot_cnt    <= '0;
      lr_prev     <= 1'b0;
    end else begin
      load_strobe <= 1'b0;
      underrun    <= 1'b0;
      frame_err   <= 1'b0;

      if (sample_valid) begin
        if (sample_ch) begin
          hold_r  <= sample_in;
          fresh_r <= 1'b1;
        end else begin
          hold_l  <= sample_in;
          fresh_l <= 1'b1;
        end
      end

      if (fe_q) lr_prev <= lr_q;

      if (do_shift) begin
        sdata_out <= shreg[DATA_W-1];
        shreg     <= shreg << 1;
      end

      if (do_load) slot_cnt <= 6'd1;
      else if (state == ACTIVE && fe_q && slot_cnt != CNT_MAX) slot_cnt <= slot_cnt + 6'd1;

      // The current bit has already been taken from shreg above; the new word replaces the shift.
      if (do_load) begin
        shreg       <= load_word;
        load_strobe <= 1'b1;
        load_ch     <= lr_q;
        underrun    <= load_underrun;
        if (lr_q) fresh_r <= 1'b0;
        else      fresh_l <= 1'b0;
      end

      if (chk_frame) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: drives bclk/lrclk (bclk = clk/16), records slot bits
// at each bclk rising edge and compares against a queue of expected slot patterns.
module tb_i2s_tx_serializer;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bclk_in = 1'b1;
  logic        lrclk_in = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ch = 1'b0;
  logic        sdata_out;
  logic        load_strobe;
  logic        load_ch;
  logic        underrun;
  logic        frame_err;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int loads_seen = 0;
  int under_seen = 0;
  int ferr_seen  = 0;

  logic [31:0] rx;
  logic        exp_c;

  typedef struct {
    string       tag;
    logic [31:0] pat;
  } exp_t;

  exp_t slot_q[$];
  logic exp_ch_q[$];

  i2s_tx_serializer #(.DATA_W(16), .SLOT_W(32), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bclk_in      (bclk_in),
    .lrclk_in     (lrclk_in),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sdata_out    (sdata_out),
    .load_strobe  (load_strobe),
    .load_ch      (load_ch),
    .underrun     (underrun),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slotPattern(input logic [15:0] word);
    return {1'b0, word, 15'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ch, input logic [15:0] val);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_in    = val;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] pat);
    exp_t e;
    e.tag = tag;
    e.pat = pat;
    slot_q.push_back(e);
  endtask

  task automatic checkSlot();
    exp_t e;
    if (slot_q.size() == 0) begin
      assert_cnt++;
      fail_cnt++;
      $error("[TB] FAIL slot: observed %h expected nothing queued", rx);
    end else begin
      e = slot_q.pop_front();
      checkOutput(e.tag, rx, e.pat);
    end
  endtask

  // One slot of nbits bclk periods; optional write strobe lands in the cycle lr_chg is seen.
  task automatic sendSlot(input logic lr, input int nbits, input bit load_exp,
                          input bit byp_en, input logic [15:0] byp_val);
    rx = '0;
    if (load_exp) exp_ch_q.push_back(lr);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      bclk_in  = 1'b0;
      lrclk_in = lr;
      if (k == 0 && byp_en) begin
        repeat (3) @(negedge clk);
        sample_valid = 1'b1;
        sample_ch    = lr;
        sample_in    = byp_val;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      bclk_in = 1'b1;
      if (k < 32) rx[31-k] = sdata_out;
      repeat (7) @(negedge clk);
    end
  endtask

  // Pulse monitor: every load is matched against the channel the bench scheduled.
  always @(negedge clk) begin
    if (load_strobe) begin
      loads_seen++;
      if (exp_ch_q.size() == 0) begin
        assert_cnt++;
        fail_cnt++;
        $error("[TB] FAIL load_ch: observed unexpected load on ch %0b expected none", load_ch);
      end else begin
        exp_c = exp_ch_q.pop_front();
        checkOutput("load_ch", {31'b0, load_ch}, {31'b0, exp_c});
      end
    end
    if (underrun)  under_seen++;
    if (frame_err) ferr_seen++;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: observed no finish expected finish within 60000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_sdata", {31'b0, sdata_out}, 32'd0);
    checkOutput("rst_load_strobe", {31'b0, load_strobe}, 32'd0);
    checkOutput("rst_underrun", {31'b0, underrun}, 32'd0);
    checkOutput("rst_frame_err", {31'b0, frame_err}, 32'd0);
    checkOutput("rst_load_ch", {31'b0, load_ch}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Basic framing, starting mid-way through a left slot
    applyStimulus(1'b0, 16'h8001);
    applyStimulus(1'b1, 16'h7FFE);
    pushExpect("startup_idle", 32'h0);
    sendSlot(1'b0, 10, 1'b0, 1'b0, 16'h0);
    checkSlot();
    checkOutput("startup_no_load", loads_seen, 32'd0);
    pushExpect("frame_r", slotPattern(16'h7FFE));
    sendSlot(1'b1, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("first_lrchg_no_ferr", ferr_seen, 32'd0);
    pushExpect("frame_l", slotPattern(16'h8001));
    sendSlot(1'b0, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("basic_loads", loads_seen, 32'd2);
    checkOutput("basic_underrun", under_seen, 32'd0);
    checkOutput("basic_ferr", ferr_seen, 32'd0);

    // Underrun on the right channel
    applyStimulus(1'b0, 16'h1234);
    pushExpect("underrun_r", slotPattern(MUTE ? 16'h0000 : 16'h7FFE));
    sendSlot(1'b1, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("underrun_pulse", under_seen, 32'd1);
    pushExpect("after_underrun_l", slotPattern(16'h1234));
    sendSlot(1'b0, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("underrun_once", under_seen, 32'd1);

    // Same-cycle bypass into the right slot
    applyStimulus(1'b0, 16'h5555);
    pushExpect("bypass_r", slotPattern(16'h0F0F));
    sendSlot(1'b1, 32, 1'b1, 1'b1, 16'h0F0F);
    checkSlot();
    checkOutput("bypass_no_underrun", under_seen, 32'd1);
    pushExpect("bypass_next_l", slotPattern(16'h5555));
    sendSlot(1'b0, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    sendSlot(1'b1, 32, 1'b1, 1'b0, 16'h0);
    checkOutput("bypass_fresh_clear", under_seen, 32'd2);

    // Short (30-bit) left slot
    applyStimulus(1'b0, 16'h00FF);
    pushExpect("short_l", slotPattern(16'h00FF));
    sendSlot(1'b0, 30, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("short_no_ferr_yet", ferr_seen, 32'd0);
    applyStimulus(1'b1, 16'hA5A5);
    pushExpect("after_short_r", slotPattern(16'hA5A5));
    sendSlot(1'b1, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("short_ferr", ferr_seen, 32'd1);
    applyStimulus(1'b0, 16'h1111);
    pushExpect("realign_l", slotPattern(16'h1111));
    sendSlot(1'b0, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("realign_ferr", ferr_seen, 32'd1);

    // Reset during bit 5 of a right word
    applyStimulus(1'b1, 16'hFFFF);
    pushExpect("pre_reset_bits", 32'h7C00_0000);
    sendSlot(1'b1, 6, 1'b1, 1'b0, 16'h0);
    checkSlot();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_sdata", {31'b0, sdata_out}, 32'd0);
    checkOutput("reset_mid_load_ch", {31'b0, load_ch}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    pushExpect("post_reset_idle", 32'h0);
    sendSlot(1'b0, 10, 1'b0, 1'b0, 16'h0);
    checkSlot();
    applyStimulus(1'b1, 16'h4321);
    pushExpect("post_reset_r", slotPattern(16'h4321));
    sendSlot(1'b1, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("post_reset_no_ferr", ferr_seen, 32'd1);
    pushExpect("post_reset_l_cleared", slotPattern(16'h0000));
    sendSlot(1'b0, 32, 1'b1, 1'b0, 16'h0);
    checkSlot();
    checkOutput("post_reset_underrun", under_seen, 32'd3);

    repeat (8) @(negedge clk);
    checkOutput("load_count", loads_seen, 32'd13);
    checkOutput("loads_all_seen", exp_ch_q.size(), 32'd0);
    checkOutput("final_ferr", ferr_seen, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- I2S transmitter on the output side of the audio path: takes filtered 16-bit samples from the biquad filter and serializes them to the DAC in standard I2S framing.
- Runs on the high-speed system clock. Bit clock and word-select clock are external inputs; they are oversampled, synchronized and edge-detected.
- One holding register per channel decouples the filter's per-sample output strobe from the serial slot timing.

Parameters:
- DATA_W, 16, sample width in bits, MSB-first on the wire.
- SLOT_W, 32, expected bclk periods per channel slot; must be >= DATA_W.
- SYNC_STAGES, 2, synchronizer flops on bclk_in and lrclk_in.

Ports:
- clk  input  1  system clock, at least 8x the bclk frequency.
- reset  input  1  synchronous, active-low.
- bclk_in  input  1  external I2S bit clock, asynchronous.
- lrclk_in  input  1  external word select, asynchronous; 0 = left, 1 = right.
- sample_in  input  DATA_W  signed sample from the filter.
- sample_valid  input  1  one-cycle write strobe.
- sample_ch  input  1  target holding register: 0 = left, 1 = right.
- sdata_out  output  1  I2S serial data.
- load_strobe  output  1  one-cycle pulse when a holding register is consumed into the shifter.
- load_ch  output  1  channel consumed at the last load_strobe.
- underrun  output  1  one-cycle pulse: the loaded channel had no fresh sample.
- frame_err  output  1  one-cycle pulse: the completed slot length was not SLOT_W.

Behaviour:
- Synchronization and edge detection:
  - bclk_in and lrclk_in each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - Action happens only on a detected bclk falling edge (fe). At fe, lr_now is the synchronized lrclk and lr_prev is the value captured at the previous fe.
  - lr_chg = fe && (lr_now != lr_prev).
- Shift path, applied on every fe:
  - sdata_out <= shreg[DATA_W-1], then shreg <= shreg << 1 with zero fill.
  - If lr_chg, shreg is loaded with the word for channel lr_now after the current bit is driven. The MSB therefore appears one bclk after the word-select transition, which is the I2S one-bit delay.
  - Bits past DATA_W within a slot are 0. With DATA_W == SLOT_W, the previous word's LSB coincides with the transition.
- Holding registers hold_l and hold_r, each with a fresh flag:
  - sample_valid writes sample_in to the register selected by sample_ch and sets its fresh flag.
  - A load clears the loaded channel's fresh flag.
- Load rules:
  - A loaded channel whose fresh flag is set loads its holding value.
  - A loaded channel whose fresh flag is clear pulses underrun and loads the fallback value (see Optional Feature).
  - If sample_valid targets the loading channel in the same clk cycle as lr_chg, sample_in is bypassed into shreg, no underrun is raised, and the fresh flag ends clear.
- State machine:
  - WAIT_SYNC: entered at reset. sdata_out = 0; no loads, no error checks. On the first lr_chg, perform a normal load (underrun rules apply) and move to ACTIVE.
  - ACTIVE: slot_cnt is set to 1 at each lr_chg and increments on every other fe, saturating at 63.
  - At each lr_chg in ACTIVE, if slot_cnt != SLOT_W, pulse frame_err. Transmission continues and the load is still performed.
- Output pulses:
  - load_strobe, underrun and frame_err are asserted for exactly one clk, in the cycle after the fe that caused them.
  - load_ch updates in that same cycle.
- Latency: sdata_out changes SYNC_STAGES+2 clk cycles after the physical bclk falling edge.
- Reset (synchronous, active-low), including mid-word:
  - Clears sdata_out, all pulse outputs, load_ch, shreg, holding registers, fresh flags, slot_cnt, lr_prev and the synchronizers.
  - Returns the block to WAIT_SYNC.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_MUTE_EN.
  - Defined: the underrun fallback value is all zeros (mute).
  - Undefined: the fallback is the channel's last holding value (repeat sample).
- The underrun pulse behaves identically in both builds.

Test Plan:
- Basic framing (clk = 16x bclk, SLOT_W = 32): write L = 0x8001, R = 0x7FFE, then run two frames.
  - Left slot: bit 0 of the slot = 0, bits 1..16 = 1000000000000001, bits 17..31 = 0.
  - Right slot: bits 1..16 = 0111111111111110.
  - load_strobe pulses twice, with load_ch = 0 then 1. No underrun, no frame_err.
- Underrun: write L only (0x1234) before a frame.
  - Right load pulses underrun.
  - MUTE_EN build: right slot data is 0x0000. Default build: right slot data is the previous right value.
- Same-cycle bypass: assert sample_valid with sample_ch = 1 and value 0x0F0F in the exact clk cycle lr_chg is detected for the right slot.
  - Right slot transmits 0x0F0F, no underrun pulse, right fresh flag ends clear.
- Short slot: make one slot 30 bclk periods long.
  - frame_err pulses once at the following transition; subsequent words stay correctly aligned.
- Startup and reset:
  - Start mid-slot after reset: sdata_out stays 0 until the first lr_chg; no frame_err on that first transition.
  - Assert reset during bit 5 of a word: sdata_out = 0 the next cycle; after release, no output until a new lr_chg.
